// File: rtl/engine_alu_ops_config_loader.sv
// ALU-ops configuration loader: collects a header plus four words into a shadow
// set and commits them to the active outputs once the engine is idle.
module engine_alu_ops_config_loader #(
   parameter int         NUM_FIELDS = 4,
   parameter int         DATA_W     = 32,
   parameter logic [7:0] ENGINE_ID  = 8'h01
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic                             cfg_in_valid,
   input  logic [31:0]                      cfg_in_data,
   output logic                             cfg_in_ready,
   input  logic                             engine_idle,
   input  logic                             clear,
   output logic                             config_params_valid,
   output logic [3:0]                       alu_operation,
   output logic [NUM_FIELDS-1:0]            alu_mask,
   output logic [NUM_FIELDS-1:0]            const_mask,
   output logic [DATA_W-1:0]                const_value,
   output logic [NUM_FIELDS*NUM_FIELDS-1:0] ops_mask,
   output logic                             cfg_done,
   output logic                             cfg_error
);

   localparam int OW = NUM_FIELDS * NUM_FIELDS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  rdy_q, rdy_d;
   logic [3:0]            sh_op_q, sh_op_d;
   logic [NUM_FIELDS-1:0] sh_am_q, sh_am_d;
   logic [NUM_FIELDS-1:0] sh_cm_q, sh_cm_d;
   logic [DATA_W-1:0]     sh_cv_q, sh_cv_d;
   logic [OW-1:0]         sh_om_q, sh_om_d;
   logic                  valid_q, valid_d;
   logic [3:0]            op_q, op_d;
   logic [NUM_FIELDS-1:0] am_q, am_d;
   logic [NUM_FIELDS-1:0] cm_q, cm_d;
   logic [DATA_W-1:0]     cv_q, cv_d;
   logic [OW-1:0]         om_q, om_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  xfer;

   assign xfer = cfg_in_valid & rdy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_op_d = sh_op_q;
      sh_am_d = sh_am_q;
      sh_cm_d = sh_cm_q;
      sh_cv_d = sh_cv_q;
      sh_om_d = sh_om_q;
      valid_d = valid_q;
      op_d    = op_q;
      am_d    = am_q;
      cm_d    = cm_q;
      cv_d    = cv_q;
      om_d    = om_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         sh_op_d = '0;
         sh_am_d = '0;
         sh_cm_d = '0;
         sh_cv_d = '0;
         sh_om_d = '0;
         valid_d = 1'b0;
         op_d    = '0;
         am_d    = '0;
         cm_d    = '0;
         cv_d    = '0;
         om_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  if (cfg_in_data[31:24] == ENGINE_ID) begin
                     state_d = S_RECV;
                     cnt_d   = 3'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (xfer) begin
                  unique case (cnt_q)
                     3'd1: begin
                        if (cfg_in_data[3:0] > 4'd5) begin
                           // Bad opcode: drop the partial shadow, keep active set
                           err_d   = 1'b1;
                           state_d = S_IDLE;
                           cnt_d   = '0;
                           sh_op_d = '0;
                           sh_am_d = '0;
                           sh_cm_d = '0;
                           sh_cv_d = '0;
                           sh_om_d = '0;
                        end else begin
                           sh_op_d = cfg_in_data[3:0];
                           sh_am_d = cfg_in_data[8 +: NUM_FIELDS];
                           cnt_d   = 3'd2;
                        end
                     end
                     3'd2: begin
                        sh_cm_d = cfg_in_data[NUM_FIELDS-1:0];
                        cnt_d   = 3'd3;
                     end
                     3'd3: begin
                        sh_cv_d = cfg_in_data[DATA_W-1:0];
                        cnt_d   = 3'd4;
                     end
                     default: begin
                        sh_om_d = cfg_in_data[OW-1:0];
                        cnt_d   = '0;
                        state_d = S_WAIT;
                     end
                  endcase
               end
            end
            default: begin
               if (engine_idle) begin
                  valid_d = 1'b1;
                  op_d    = sh_op_q;
                  am_d    = sh_am_q;
                  cm_d    = sh_cm_q;
                  cv_d    = sh_cv_q;
                  om_d    = sh_om_q;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         endcase
      end
      // Registered ready mirrors the next state so it stays low in reset
      rdy_d = (state_d != S_WAIT);
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         sh_op_q <= '0;
         sh_am_q <= '0;
         sh_cm_q <= '0;
         sh_cv_q <= '0;
         sh_om_q <= '0;
         valid_q <= 1'b0;
         op_q    <= '0;
         am_q    <= '0;
         cm_q    <= '0;
         cv_q    <= '0;
         om_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
         sh_op_q <= sh_op_d;
         sh_am_q <= sh_am_d;
         sh_cm_q <= sh_cm_d;
         sh_cv_q <= sh_cv_d;
         sh_om_q <= sh_om_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         am_q    <= am_d;
         cm_q    <= cm_d;
         cv_q    <= cv_d;
         om_q    <= om_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cfg_in_ready        = rdy_q;
   assign config_params_valid = valid_q;
   assign alu_operation       = op_q;
   assign alu_mask            = am_q;
   assign const_mask          = cm_q;
   assign const_value         = cv_q;
   assign ops_mask            = om_q;
   assign cfg_done            = done_q;
   assign cfg_error           = err_q;

endmodule

// File: tb/tb_engine_alu_ops_config_loader.sv
// Scoreboard bench for engine_alu_ops_config_loader: the driver pushes expected
// commit/error events, the monitor pops them on cfg_done/cfg_error.
module tb_engine_alu_ops_config_loader;

   logic        ap_clk;
   logic        ap_rst_n;
   logic        cfg_in_valid;
   logic [31:0] cfg_in_data;
   logic        cfg_in_ready;
   logic        engine_idle;
   logic        clear;
   logic        config_params_valid;
   logic [3:0]  alu_operation;
   logic [3:0]  alu_mask;
   logic [3:0]  const_mask;
   logic [31:0] const_value;
   logic [15:0] ops_mask;
   logic        cfg_done;
   logic        cfg_error;

   engine_alu_ops_config_loader dut (
      .ap_clk              (ap_clk),
      .ap_rst_n            (ap_rst_n),
      .cfg_in_valid        (cfg_in_valid),
      .cfg_in_data         (cfg_in_data),
      .cfg_in_ready        (cfg_in_ready),
      .engine_idle         (engine_idle),
      .clear               (clear),
      .config_params_valid (config_params_valid),
      .alu_operation       (alu_operation),
      .alu_mask            (alu_mask),
      .const_mask          (const_mask),
      .const_value         (const_value),
      .ops_mask            (ops_mask),
      .cfg_done            (cfg_done),
      .cfg_error           (cfg_error)
   );

   typedef struct {
      bit          is_err;
      logic [3:0]  op;
      logic [3:0]  am;
      logic [3:0]  cm;
      logic [31:0] cv;
      logic [15:0] om;
   } exp_t;

   exp_t q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int drv_tmo = 0;
   int tmo_seen = 0;
   int idle_mode = 0;
   bit mon_en = 0;
   bit chk_wait = 0;
   bit chk_rdy1 = 0;
   bit rst_pend = 0;
   bit clr_pend = 0;

   logic        x_valid;
   logic [3:0]  x_op;
   logic [3:0]  x_am;
   logic [3:0]  x_cm;
   logic [31:0] x_cv;
   logic [15:0] x_om;

   initial begin
      ap_clk = 0;
      forever #5 ap_clk = ~ap_clk;
   end

   always @(posedge ap_clk) begin
      #1;
      case (idle_mode)
         0:       engine_idle = 1'b1;
         1:       engine_idle = 1'($urandom_range(0, 1));
         default: engine_idle = 1'b0;
      endcase
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   always @(negedge ap_clk) begin
      exp_t e;
      if (rst_pend) begin
         chk("reset_outputs",
             {cfg_in_ready, config_params_valid, alu_operation, alu_mask,
              const_mask, const_value, ops_mask, cfg_done, cfg_error}, 64'd0);
         {x_valid, x_op, x_am, x_cm, x_cv, x_om} = '0;
      end else if (mon_en) begin
         if (clr_pend) {x_valid, x_op, x_am, x_cm, x_cv, x_om} = '0;
         if (drv_tmo != tmo_seen) begin
            tmo_seen = drv_tmo;
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: driver bound expired (%0d total)", drv_tmo);
         end
         if (cfg_done && cfg_error) chk("done_and_error", 2'b11, 2'b01);
         if (cfg_done || cfg_error) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pulse: done=%0b error=%0b, nothing expected",
                        cfg_done, cfg_error);
            end else begin
               e = q.pop_front();
               chk("event_kind", {63'd0, cfg_error}, {63'd0, e.is_err});
               if (!e.is_err) begin
                  x_valid = 1'b1;
                  x_op = e.op;
                  x_am = e.am;
                  x_cm = e.cm;
                  x_cv = e.cv;
                  x_om = e.om;
               end
            end
         end
         chk("active_config",
             {3'd0, config_params_valid, alu_operation, alu_mask, const_mask,
              const_value, ops_mask},
             {3'd0, x_valid, x_op, x_am, x_cm, x_cv, x_om});
         if (chk_wait) chk("wait_ready_low", {cfg_in_ready, cfg_done}, 2'b00);
         if (chk_rdy1) chk("ready_after_reset", {63'd0, cfg_in_ready}, 64'd1);
      end
      rst_pend = !ap_rst_n;
      clr_pend = clear;
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      int  n;
      bit  rdy;
      repeat ($urandom_range(0, 2)) tick();
      cfg_in_valid = 1'b1;
      cfg_in_data  = w;
      n = 0;
      forever begin
         @(negedge ap_clk);
         rdy = cfg_in_ready;
         tick();
         if (rdy) break;
         n++;
         if (n > 200) begin
            drv_tmo++;
            break;
         end
      end
      cfg_in_valid = 1'b0;
      cfg_in_data  = $urandom;
   endtask

   task automatic do_clear();
      cfg_in_valid = 1'b1;
      cfg_in_data  = {8'h01, 24'($urandom)};
      clear = 1'b1;
      tick();
      clear = 1'b0;
      cfg_in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (q.size() != 0) begin
         drv_tmo++;
         q.delete();
      end
      tick();
   endtask

   task automatic do_txn(input logic [31:0] hdr, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic [31:0] w4, input int clr_after,
                         input bit hold);
      exp_t e;
      e = '{is_err: 1'b1, op: 4'd0, am: 4'd0, cm: 4'd0, cv: 32'd0, om: 16'd0};
      send_word(hdr);
      if (hdr / 32'h0100_0000 != 32'd1) begin
         q.push_back(e);
         drain();
         return;
      end
      send_word(w1);
      if (w1 % 16 > 5) begin
         q.push_back(e);
         drain();
         return;
      end
      if (hold) idle_mode = 2;
      if (clr_after == 1) begin do_clear(); drain(); return; end
      send_word(w2);
      if (clr_after == 2) begin do_clear(); drain(); return; end
      send_word(w3);
      if (clr_after == 3) begin do_clear(); drain(); return; end
      e.is_err = 1'b0;
      e.op = 4'(w1 % 16);
      e.am = 4'((w1 / 256) % 16);
      e.cm = 4'(w2 % 16);
      e.cv = w3;
      e.om = 16'(w4 % 65536);
      q.push_back(e);
      send_word(w4);
      if (hold) begin
         chk_wait = 1'b1;
         repeat (10) tick();
         chk_wait = 1'b0;
         idle_mode = 0;
      end
      drain();
   endtask

   initial begin
      logic [7:0]  id;
      logic [31:0] w1;
      ap_rst_n = 1'b0;
      cfg_in_valid = 1'b0;
      cfg_in_data = '0;
      clear = 1'b0;
      engine_idle = 1'b1;
      {x_valid, x_op, x_am, x_cm, x_cv, x_om} = '0;
      repeat (3) tick();
      ap_rst_n = 1'b1;
      mon_en = 1'b1;
      tick();
      chk_rdy1 = 1'b1;
      tick();
      chk_rdy1 = 1'b0;

      do_txn(32'h0100_0000, 32'h0000_0301, 32'h4, 32'h2A, 32'h8421, 0, 0);
      do_txn(32'h0700_0000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      do_txn(32'h0100_0000, 32'h0000_0502, 32'hFFFF_FFF3, 32'h1, 32'hABCD_0001, 0, 0);
      do_txn(32'h0100_0000, 32'h0000_0301, 32'h4, 32'h2A, 32'h8421, 0, 0);
      do_txn(32'h0100_0000, 32'h0000_0009, 32'h0, 32'h0, 32'h0, 0, 0);
      do_txn(32'h01AB_CDEF, 32'hFFFF_F405, 32'h5, 32'hDEAD_BEEF, 32'h1234, 0, 1);
      do_txn(32'h0100_0000, 32'h0000_0303, 32'h7, 32'h9, 32'h5555, 2, 0);
      do_txn(32'h0100_0000, 32'h0000_0C00, 32'h8, 32'h0, 32'hFFFF, 0, 0);

      for (int i = 0; i < 40; i++) begin
         idle_mode = int'($urandom_range(0, 1));
         id = 8'h01;
         if ($urandom_range(0, 7) == 0) begin
            id = 8'($urandom_range(0, 255));
            if (id == 8'h01) id = 8'hFF;
         end
         w1 = $urandom;
         w1[3:0] = 4'($urandom_range(0, 7));
         do_txn({id, 24'($urandom)}, w1, $urandom, $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 9) == 0));
      end
      idle_mode = 0;
      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
